// File: rtl/vuvxu_b8_seq.sv
// Sequencer after the Banked8 fire stage: queues fired vector ops in order and
// expands the head op into per-group bank addresses, lane masks and a last flag.
// Optional perf counters are built when VUVXU_SEQ_PERF_EN is defined.
module vuvxu_b8_seq #(
  parameter int unsigned BANKS  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned VLEN_W = 11,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned FN_W   = 11,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [VLEN_W-1:0] cfg_vlen,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [8:0]        fire_unit,
  input  logic [FN_W-1:0]   fire_fn,
  input  logic [ADDR_W-1:0] fire_vs,
  input  logic [ADDR_W-1:0] fire_vt,
  input  logic [ADDR_W-1:0] fire_vr,
  input  logic [ADDR_W-1:0] fire_vd,
  input  logic              fire_vs_zero,
  input  logic              fire_vt_zero,
  input  logic              fire_vr_zero,
  input  logic [DATA_W-1:0] fire_imm,
  output logic              seq_rdy,
  output logic              seq_val,
  input  logic              seq_ack,
  output logic [8:0]        seq_unit,
  output logic [FN_W-1:0]   seq_fn,
  output logic [ADDR_W-1:0] seq_vs_addr,
  output logic [ADDR_W-1:0] seq_vt_addr,
  output logic [ADDR_W-1:0] seq_vr_addr,
  output logic [ADDR_W-1:0] seq_vd_addr,
  output logic              seq_vs_zero,
  output logic              seq_vt_zero,
  output logic              seq_vr_zero,
  output logic [DATA_W-1:0] seq_imm,
  output logic [BANKS-1:0]  seq_mask,
  output logic              seq_last,
  output logic              seq_err
`ifdef VUVXU_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_groups,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SH     = $clog2(BANKS);
  localparam int unsigned VW1    = VLEN_W + 1;
  localparam int unsigned UNIT_W = 9;

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic [FN_W-1:0]   fn;
    logic              vs_zero;
    logic              vt_zero;
    logic              vr_zero;
    logic [DATA_W-1:0] imm;
    logic [VLEN_W-1:0] vlen;
    logic [VLEN_W-1:0] ngroups;
    logic [ADDR_W-1:0] vs_base;
    logic [ADDR_W-1:0] vt_base;
    logic [ADDR_W-1:0] vr_base;
    logic [ADDR_W-1:0] vd_base;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt, rd_ptr_p1;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [VLEN_W-1:0] grp, grp_nxt;

  logic              fire, multi, push, adv, pop, err_nxt;
  logic [VW1-1:0]    vlen_rnd;
  logic [ADDR_W-1:0] vs_base_c, vt_base_c, vr_base_c, vd_base_c;
  entry_t            new_ent, head_nxt;
  logic [VLEN_W-1:0] rem;

  logic              val_nxt, last_nxt;
  logic [BANKS-1:0]  mask_nxt;
  logic [ADDR_W-1:0] vs_addr_nxt, vt_addr_nxt, vr_addr_nxt, vd_addr_nxt;

  // Queue control and next-head selection; outputs are built from the next state
  always_comb begin
    fire       = |fire_unit;
    multi      = |(fire_unit & (fire_unit - UNIT_W'(1)));
    push       = fire & seq_rdy & (cfg_vlen != '0);
    adv        = seq_val & seq_ack;
    pop        = adv & seq_last;
    err_nxt    = seq_err | (fire & ~seq_rdy) | (push & multi);
    rd_ptr_p1  = rd_ptr + PTR_W'(1);
    rd_ptr_nxt = pop  ? rd_ptr_p1 : rd_ptr;
    wr_ptr_nxt = push ? wr_ptr + PTR_W'(1) : wr_ptr;

    count_nxt = count;
    if (push && !pop) count_nxt = count + CNT_W'(1);
    if (pop && !push) count_nxt = count - CNT_W'(1);

    grp_nxt = grp;
    if (pop)      grp_nxt = '0;
    else if (adv) grp_nxt = grp + VLEN_W'(1);

    vlen_rnd  = {1'b0, cfg_vlen} + VW1'(BANKS - 1);
    vs_base_c = fire_vs * cfg_stride;
    vt_base_c = fire_vt * cfg_stride;
    vr_base_c = fire_vr * cfg_stride;
    vd_base_c = fire_vd * cfg_stride;

    new_ent         = '0;
    new_ent.unit    = fire_unit;
    new_ent.fn      = fire_fn;
    new_ent.vs_zero = fire_vs_zero;
    new_ent.vt_zero = fire_vt_zero;
    new_ent.vr_zero = fire_vr_zero;
    new_ent.imm     = fire_imm;
    new_ent.vlen    = cfg_vlen;
    new_ent.ngroups = VLEN_W'(vlen_rnd >> SH);
    new_ent.vs_base = vs_base_c;
    new_ent.vt_base = vt_base_c;
    new_ent.vr_base = vr_base_c;
    new_ent.vd_base = vd_base_c;

    head_nxt = '0;
    val_nxt  = 1'b0;
    if (count_nxt != '0) begin
      val_nxt = 1'b1;
      if (pop)                head_nxt = (count > CNT_W'(1)) ? mem[rd_ptr_p1] : new_ent;
      else if (count == '0)   head_nxt = new_ent;
      else                    head_nxt = mem[rd_ptr];
    end
  end

  // Per-group lane mask, last flag and bank addresses for the next head/group
  always_comb begin
    rem = head_nxt.vlen - (grp_nxt << SH);
    mask_nxt = '0;
    for (int unsigned i = 0; i < BANKS; i++) begin
      mask_nxt[i] = val_nxt & (VLEN_W'(i) < rem);
    end
    last_nxt    = val_nxt & (grp_nxt == head_nxt.ngroups - VLEN_W'(1));
    vs_addr_nxt = head_nxt.vs_zero ? '0 : head_nxt.vs_base + ADDR_W'(grp_nxt);
    vt_addr_nxt = head_nxt.vt_zero ? '0 : head_nxt.vt_base + ADDR_W'(grp_nxt);
    vr_addr_nxt = head_nxt.vr_zero ? '0 : head_nxt.vr_base + ADDR_W'(grp_nxt);
    vd_addr_nxt = val_nxt ? head_nxt.vd_base + ADDR_W'(grp_nxt) : '0;
  end

  // Entry storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_ent;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      grp         <= '0;
      seq_rdy     <= 1'b1;
      seq_err     <= 1'b0;
      seq_val     <= 1'b0;
      seq_unit    <= '0;
      seq_fn      <= '0;
      seq_vs_addr <= '0;
      seq_vt_addr <= '0;
      seq_vr_addr <= '0;
      seq_vd_addr <= '0;
      seq_vs_zero <= 1'b0;
      seq_vt_zero <= 1'b0;
      seq_vr_zero <= 1'b0;
      seq_imm     <= '0;
      seq_mask    <= '0;
      seq_last    <= 1'b0;
    end else begin
      rd_ptr      <= rd_ptr_nxt;
      wr_ptr      <= wr_ptr_nxt;
      count       <= count_nxt;
      grp         <= grp_nxt;
      seq_rdy     <= count_nxt < CNT_W'(DEPTH);
      seq_err     <= err_nxt;
      seq_val     <= val_nxt;
      seq_unit    <= head_nxt.unit;
      seq_fn      <= head_nxt.fn;
      seq_vs_addr <= vs_addr_nxt;
      seq_vt_addr <= vt_addr_nxt;
      seq_vr_addr <= vr_addr_nxt;
      seq_vd_addr <= vd_addr_nxt;
      seq_vs_zero <= head_nxt.vs_zero;
      seq_vt_zero <= head_nxt.vt_zero;
      seq_vr_zero <= head_nxt.vr_zero;
      seq_imm     <= head_nxt.imm;
      seq_mask    <= mask_nxt;
      seq_last    <= last_nxt;
    end
  end

`ifdef VUVXU_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_ops    <= '0;
      perf_groups <= '0;
      perf_stall  <= '0;
    end else begin
      if (pop)                 perf_ops    <= perf_ops + 32'd1;
      if (adv)                 perf_groups <= perf_groups + 32'd1;
      if (seq_val && !seq_ack) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vuvxu_b8_seq.sv
// Directed bench for vuvxu_b8_seq: a queue-level reference model checked every
// cycle, plus literal expectations for the hand-computed scenarios.
module tb_vuvxu_b8_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] cfg_vlen;
  logic [7:0]  cfg_stride;
  logic [8:0]  fire_unit;
  logic [10:0] fire_fn;
  logic [7:0]  fire_vs, fire_vt, fire_vr, fire_vd;
  logic        fire_vs_zero, fire_vt_zero, fire_vr_zero;
  logic [63:0] fire_imm;
  logic        seq_rdy, seq_val, seq_ack;
  logic [8:0]  seq_unit;
  logic [10:0] seq_fn;
  logic [7:0]  seq_vs_addr, seq_vt_addr, seq_vr_addr, seq_vd_addr;
  logic        seq_vs_zero, seq_vt_zero, seq_vr_zero;
  logic [63:0] seq_imm;
  logic [7:0]  seq_mask;
  logic        seq_last, seq_err;

  int n_vec = 0;
  int n_err = 0;

  vuvxu_b8_seq dut (
    .clk(clk), .reset(reset), .cfg_vlen(cfg_vlen), .cfg_stride(cfg_stride),
    .fire_unit(fire_unit), .fire_fn(fire_fn), .fire_vs(fire_vs), .fire_vt(fire_vt),
    .fire_vr(fire_vr), .fire_vd(fire_vd), .fire_vs_zero(fire_vs_zero),
    .fire_vt_zero(fire_vt_zero), .fire_vr_zero(fire_vr_zero), .fire_imm(fire_imm),
    .seq_rdy(seq_rdy), .seq_val(seq_val), .seq_ack(seq_ack), .seq_unit(seq_unit),
    .seq_fn(seq_fn), .seq_vs_addr(seq_vs_addr), .seq_vt_addr(seq_vt_addr),
    .seq_vr_addr(seq_vr_addr), .seq_vd_addr(seq_vd_addr), .seq_vs_zero(seq_vs_zero),
    .seq_vt_zero(seq_vt_zero), .seq_vr_zero(seq_vr_zero), .seq_imm(seq_imm),
    .seq_mask(seq_mask), .seq_last(seq_last), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
    end
  endfunction

  // Reference model: a queue of whole operations plus the head's group index
  typedef struct {
    logic [8:0]  unit;
    logic [10:0] fn;
    bit          zs, zt, zr;
    logic [63:0] imm;
    int          vlen;
    int          bvs, bvt, bvr, bvd;
  } op_t;

  op_t mq[$];
  int  mg;
  bit  merr;

  function automatic int ngr(input int vlen);
    return (vlen + 7) / 8;
  endfunction

  function automatic int gaddr(input int base, input int g, input bit z);
    return z ? 0 : (base + g) % 256;
  endfunction

  function automatic void compare_all();
    op_t o;
    int  rem;
    int  emask;
    chk("rdy", seq_rdy, 64'(mq.size() < 4));
    chk("err", seq_err, 64'(merr));
    chk("val", seq_val, 64'(mq.size() > 0));
    if (mq.size() > 0) begin
      o = mq[0];
      rem = o.vlen - mg * 8;
      emask = (rem >= 8) ? 255 : ((1 << rem) - 1);
      chk("unit", seq_unit, 64'(o.unit));
      chk("fn", seq_fn, 64'(o.fn));
      chk("imm", seq_imm, o.imm);
      chk("zeros", {seq_vs_zero, seq_vt_zero, seq_vr_zero}, {61'd0, o.zs, o.zt, o.zr});
      chk("vs_addr", seq_vs_addr, 64'(gaddr(o.bvs, mg, o.zs)));
      chk("vt_addr", seq_vt_addr, 64'(gaddr(o.bvt, mg, o.zt)));
      chk("vr_addr", seq_vr_addr, 64'(gaddr(o.bvr, mg, o.zr)));
      chk("vd_addr", seq_vd_addr, 64'(gaddr(o.bvd, mg, 1'b0)));
      chk("mask", seq_mask, 64'(emask));
      chk("last", seq_last, 64'(mg == ngr(o.vlen) - 1));
    end else begin
      chk("idle_out", {seq_unit, seq_fn, seq_vs_addr, seq_vd_addr, seq_mask, seq_last},
          64'd0);
    end
  endfunction

  always @(posedge clk) begin
    bit  rdy;
    op_t o;
    if (!reset) begin
      mq.delete();
      mg   = 0;
      merr = 1'b0;
    end else begin
      rdy = mq.size() < 4;
      if (mq.size() > 0 && seq_ack) begin
        if (mg == ngr(mq[0].vlen) - 1) begin
          mq.delete(0);
          mg = 0;
        end else begin
          mg++;
        end
      end
      if (fire_unit != 9'd0) begin
        if (!rdy) merr = 1'b1;
        else if (cfg_vlen != 11'd0) begin
          o.unit = fire_unit;
          o.fn   = fire_fn;
          o.zs   = fire_vs_zero;
          o.zt   = fire_vt_zero;
          o.zr   = fire_vr_zero;
          o.imm  = fire_imm;
          o.vlen = int'(cfg_vlen);
          o.bvs  = (int'(fire_vs) * int'(cfg_stride)) % 256;
          o.bvt  = (int'(fire_vt) * int'(cfg_stride)) % 256;
          o.bvr  = (int'(fire_vr) * int'(cfg_stride)) % 256;
          o.bvd  = (int'(fire_vd) * int'(cfg_stride)) % 256;
          mq.push_back(o);
          if ($countones(fire_unit) > 1) merr = 1'b1;
        end
      end
      #1;
      if (reset) compare_all();
    end
  end

  task automatic nc();
    @(negedge clk);
  endtask

  task automatic fire(input logic [8:0] u, input logic [7:0] vs, input logic [7:0] vt,
                      input logic [7:0] vr, input logic [7:0] vd, input logic zs,
                      input logic [10:0] vlen, input logic [7:0] stride);
    fire_unit    = u;
    fire_vs      = vs;
    fire_vt      = vt;
    fire_vr      = vr;
    fire_vd      = vd;
    fire_vs_zero = zs;
    fire_vt_zero = 1'b0;
    fire_vr_zero = (vr == 8'd0);
    fire_fn      = 11'(vs) + 11'd100;
    fire_imm     = 64'hA5A5_0000_0000_0000 | 64'(vd);
    cfg_vlen     = vlen;
    cfg_stride   = stride;
  endtask

  initial begin
    cfg_vlen = '0; cfg_stride = '0; fire_unit = '0; fire_fn = '0;
    fire_vs = '0; fire_vt = '0; fire_vr = '0; fire_vd = '0;
    fire_vs_zero = 1'b0; fire_vt_zero = 1'b0; fire_vr_zero = 1'b0;
    fire_imm = '0; seq_ack = 1'b0;

    // Reset and idle
    repeat (2) nc();
    chk("rst_rdy", seq_rdy, 64'd1);
    chk("rst_val", seq_val, 64'd0);
    chk("rst_err", seq_err, 64'd0);
    chk("rst_outs", {seq_mask, seq_vs_addr, seq_vd_addr, seq_last, seq_unit}, 64'd0);
    chk("rst_imm", seq_imm, 64'd0);
    reset = 1'b1;
    repeat (2) nc();
    chk("idle_val", seq_val, 64'd0);

    // Reset asserted mid-operation
    fire(9'h001, 8'd2, 8'd4, 8'd1, 8'd5, 1'b0, 11'd20, 8'd3);
    nc();
    fire_unit = '0;
    chk("mid_val_pre", seq_val, 64'd1);
    #2 reset = 1'b0;
    #1 chk("mid_val_rst", seq_val, 64'd0);
    nc();
    reset = 1'b1;
    nc();
    chk("mid_val_post", seq_val, 64'd0);
    chk("mid_rdy_post", seq_rdy, 64'd1);

    // vlen=20 stride=3: three groups
    seq_ack = 1'b1;
    fire(9'h001, 8'd2, 8'd4, 8'd1, 8'd5, 1'b0, 11'd20, 8'd3);
    nc();
    fire_unit = '0;
    chk("g0_vs", seq_vs_addr, 64'd6);
    chk("g0_vd", seq_vd_addr, 64'd15);
    chk("g0_mask", seq_mask, 64'hFF);
    chk("g0_last", seq_last, 64'd0);
    nc();
    chk("g1_vs", seq_vs_addr, 64'd7);
    chk("g1_vd", seq_vd_addr, 64'd16);
    chk("g1_mask", seq_mask, 64'hFF);
    chk("g1_last", seq_last, 64'd0);
    nc();
    chk("g2_vs", seq_vs_addr, 64'd8);
    chk("g2_vd", seq_vd_addr, 64'd17);
    chk("g2_mask", seq_mask, 64'h0F);
    chk("g2_last", seq_last, 64'd1);
    nc();
    chk("g3_val", seq_val, 64'd0);

    // Back-to-back ops, no bubble
    fire(9'h002, 8'd0, 8'd0, 8'd0, 8'd1, 1'b0, 11'd8, 8'd1);
    nc();
    fire(9'h004, 8'd0, 8'd0, 8'd0, 8'd10, 1'b0, 11'd16, 8'd1);
    chk("b2b_op0_vd", seq_vd_addr, 64'd1);
    chk("b2b_op0_last", seq_last, 64'd1);
    nc();
    fire_unit = '0;
    chk("b2b_op1g0_val", seq_val, 64'd1);
    chk("b2b_op1g0_vd", seq_vd_addr, 64'd10);
    chk("b2b_op1g0_last", seq_last, 64'd0);
    nc();
    chk("b2b_op1g1_vd", seq_vd_addr, 64'd11);
    chk("b2b_op1g1_last", seq_last, 64'd1);
    nc();
    chk("b2b_done", seq_val, 64'd0);

    // Fill the queue, overflow fire, stall
    seq_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fill_rdy", seq_rdy, 64'd1);
      fire(9'h010, 8'(i + 1), 8'd3, 8'd2, 8'(i + 8), 1'b0, 11'd16, 8'd2);
      nc();
    end
    fire_unit = '0;
    chk("full_rdy", seq_rdy, 64'd0);
    chk("full_err", seq_err, 64'd0);
    fire(9'h020, 8'd7, 8'd7, 8'd7, 8'd7, 1'b0, 11'd8, 8'd2);
    nc();
    fire_unit = '0;
    chk("ovf_err", seq_err, 64'd1);
    chk("ovf_head_vs", seq_vs_addr, 64'd2);
    repeat (5) nc();
    chk("stall_vs", seq_vs_addr, 64'd2);
    chk("stall_mask", seq_mask, 64'hFF);
    chk("stall_last", seq_last, 64'd0);
    seq_ack = 1'b1;
    repeat (8) nc();
    chk("drain_val", seq_val, 64'd0);
    chk("drain_err", seq_err, 64'd1);

    // Multi-bit fire enqueues and flags
    reset = 1'b0;
    nc();
    reset = 1'b1;
    nc();
    fire(9'h003, 8'd1, 8'd1, 8'd1, 8'd2, 1'b0, 11'd8, 8'd1);
    nc();
    fire_unit = '0;
    chk("multi_val", seq_val, 64'd1);
    chk("multi_unit", seq_unit, 64'h003);
    chk("multi_err", seq_err, 64'd1);
    nc();
    chk("multi_done", seq_val, 64'd0);

    // vlen=0 fire is dropped silently
    reset = 1'b0;
    nc();
    reset = 1'b1;
    nc();
    fire(9'h001, 8'd1, 8'd1, 8'd1, 8'd2, 1'b0, 11'd0, 8'd1);
    nc();
    fire_unit = '0;
    chk("vl0_val", seq_val, 64'd0);
    chk("vl0_err", seq_err, 64'd0);

    // Zero operand, single lane
    fire(9'h002, 8'd9, 8'd3, 8'd0, 8'd6, 1'b1, 11'd1, 8'd4);
    nc();
    fire_unit = '0;
    chk("z_vs", seq_vs_addr, 64'd0);
    chk("z_vs_zero", seq_vs_zero, 64'd1);
    chk("z_vt", seq_vt_addr, 64'd12);
    chk("z_vd", seq_vd_addr, 64'd24);
    chk("z_mask", seq_mask, 64'h01);
    chk("z_last", seq_last, 64'd1);

    // Base address truncation and wrap: 3*200 = 600 -> 88
    fire(9'h100, 8'd1, 8'd1, 8'd1, 8'd3, 1'b0, 11'd9, 8'd200);
    nc();
    fire_unit = '0;
    chk("wrap_vd", seq_vd_addr, 64'd88);
    nc();
    chk("wrap_vd_g1", seq_vd_addr, 64'd89);
    chk("wrap_mask_g1", seq_mask, 64'h01);
    repeat (2) nc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vuvxu_b8_seq.md
Name: vuvxu_b8_seq

Overview:
- Sequencer stage directly downstream of the Banked8 fire stage.
- Captures each fired vector operation (unit, function, operand registers, immediate) into a small in-order queue.
- Expands the head operation into one element group per cycle across the 8 banks, with per-group bank addresses, a lane mask and a last flag, for the bank/execute pipeline.
- Its seq_rdy output feeds back into the issue stage's rdy terms.

Parameters:
- BANKS, 8, lanes per element group; width of seq_mask.
- DEPTH, 4, queue entries (power of 2, at least 2).
- VLEN_W, 11, width of the vector-length field.
- ADDR_W, 8, bank register address width.
- FN_W, 11, function-code width.
- DATA_W, 64, immediate width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cfg_vlen  in  VLEN_W  current vector length; sampled at enqueue.
- cfg_stride  in  ADDR_W  bank rows per vector register; sampled at enqueue.
- fire_unit  in  9  one-hot fire bits, index order: 0 viu, 1 vau0, 2 vau1, 3 vau2, 4 vgslu, 5 vglu, 6 vgsu, 7 vlu, 8 vsu.
- fire_fn  in  FN_W  function code of the fired operation.
- fire_vs, fire_vt, fire_vr, fire_vd  in  ADDR_W each  operand and destination registers.
- fire_vs_zero, fire_vt_zero, fire_vr_zero  in  1 each  operand reads x0.
- fire_imm  in  DATA_W  immediate.
- seq_rdy  out  1  queue can accept a fire this cycle.
- seq_val  out  1  group presented.
- seq_ack  in  1  downstream accepts the presented group.
- seq_unit  out  9  unit bits of the head entry.
- seq_fn  out  FN_W  function code of the head entry.
- seq_vs_addr, seq_vt_addr, seq_vr_addr, seq_vd_addr  out  ADDR_W each  bank addresses for the current group.
- seq_vs_zero, seq_vt_zero, seq_vr_zero  out  1 each  zero-operand flags of the head entry.
- seq_imm  out  DATA_W  immediate of the head entry.
- seq_mask  out  BANKS  active lanes in the current group.
- seq_last  out  1  current group is the final group of the operation.
- seq_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - queue empty, group counter 0, seq_err 0.
  - seq_val, seq_unit, seq_fn, all addresses, zero flags, seq_imm, seq_mask, seq_last all 0.
  - seq_rdy 1, since the queue is empty.
  - Reset asserted mid-operation discards all entries; no partial-group output follows release.
- Enqueue:
  - Occurs at the clock edge when fire_unit is nonzero, seq_rdy=1 and cfg_vlen is nonzero.
  - Stored per entry: unit, fn, zero flags, imm.
  - Stored group count: ngroups = ceil(cfg_vlen/BANKS).
  - Stored base address per operand: base = reg*cfg_stride, truncated to ADDR_W.
  - cfg changes after enqueue have no effect on queued entries.
- cfg_vlen=0 with a fire: the operation is dropped (not queued); no output and no error.
- seq_rdy = (occupancy < DEPTH). It depends on registered state only; a same-cycle pop does not raise it.
- Fire with seq_rdy=0: the operation is not enqueued and seq_err is set.
- More than one fire_unit bit set: the entry is enqueued unchanged and seq_err is set.
- seq_err stays set until reset.
- Latency: a fire at edge t makes seq_val high after edge t, i.e. group 0 is presented in the cycle following the enqueue edge.
- Output while the queue is non-empty (group index g):
  - seq_val=1.
  - Each address = base + g, truncated to ADDR_W, wrapping modulo 2^ADDR_W.
  - An address whose zero flag is set is forced to 0.
  - seq_vd_addr is always base_vd + g.
- Lane mask: rem = vlen - g*BANKS. seq_mask = all ones if rem >= BANKS, otherwise the low rem bits set.
- seq_last = (g == ngroups-1).
- Advance: when seq_val & seq_ack, g increments.
- Pop: on an acked last group the entry is popped and g resets to 0. The next entry's group 0 is presented the following cycle with no bubble.
- Stall: with seq_ack=0, all seq_* outputs hold stable.
- Simultaneous pop and push: occupancy stays unchanged; queue pointers wrap modulo DEPTH.
- Operations complete strictly in enqueue order.

Optional Feature:
- Macro VUVXU_SEQ_PERF_EN.
- When defined, the block adds three outputs, all cleared by reset and wrapping on overflow:
  - perf_ops (32 bits): counts popped operations.
  - perf_groups (32 bits): counts acked groups.
  - perf_stall (32 bits): counts cycles with seq_val=1 and seq_ack=0.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then idle: seq_rdy=1, seq_val=0, seq_err=0, all outputs 0. Release reset mid-operation after a fire: queue empty, seq_val=0.
- cfg_vlen=20, cfg_stride=3, fire viu with vs=2, vd=5, seq_ack=1:
  - 3 groups, vs_addr 6,7,8 and vd_addr 15,16,17.
  - masks 0xFF, 0xFF, 0x0F; seq_last high only on group 2.
- Two back-to-back fires (vlen 8 then 16), seq_ack=1: groups presented op0 g0, op1 g0, op1 g1 in consecutive cycles with no bubble.
- Fill queue: 4 fires with seq_ack=0 → seq_rdy drops to 0. A 5th fire → not enqueued, seq_err=1. Hold seq_ack=0 for 5 cycles → outputs stable.
- fire_unit=0x003 (two bits set) → entry enqueued, seq_err=1. cfg_vlen=0 with fire → no entry, seq_err unchanged.
- fire vau0 with vs_zero=1, vs=9, vlen=1 → seq_vs_addr=0, seq_vs_zero=1, mask 0x01, seq_last=1.
